// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, valid/ready on both sides.
// Define AES_DEC_KEY_LATCH_EN to capture all 11 round keys at accept so key ports may change while busy.
module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_in,
    input  logic [127:0] key,
    input  logic [127:0] round1_key,
    input  logic [127:0] round2_key,
    input  logic [127:0] round3_key,
    input  logic [127:0] round4_key,
    input  logic [127:0] round5_key,
    input  logic [127:0] round6_key,
    input  logic [127:0] round7_key,
    input  logic [127:0] round8_key,
    input  logic [127:0] round9_key,
    input  logic [127:0] round10_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_out,
    output logic         busy
);

    // Handshake: a transfer happens on a posedge where valid and ready are both high;
    // in_ready is high only in IDLE and out_valid only in DONE, so they never overlap.
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] rk_src [0:10];
    logic [127:0] rk_sel;
    logic [127:0] sub_out;
    logic [127:0] ark;
    logic [127:0] round_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 by repeated squaring: r accumulates x^2 * x^4 * ... * x^128; 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] d;
        d = 8'h05;
        for (int i = 0; i < 8; i++)
            a[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ d[i];
        return gf_inv(a);
    endfunction

    // Byte (row r, column c) sits at index r + 4c, MSB first.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

`ifdef AES_DEC_KEY_LATCH_EN
    logic [127:0] k_lat [0:10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) k_lat[i] <= '0;
        end else if (state == S_IDLE && in_valid) begin
            k_lat[0]  <= key;
            k_lat[1]  <= round1_key;
            k_lat[2]  <= round2_key;
            k_lat[3]  <= round3_key;
            k_lat[4]  <= round4_key;
            k_lat[5]  <= round5_key;
            k_lat[6]  <= round6_key;
            k_lat[7]  <= round7_key;
            k_lat[8]  <= round8_key;
            k_lat[9]  <= round9_key;
            k_lat[10] <= round10_key;
        end
    end

    always_comb begin
        for (int i = 0; i < 11; i++) rk_src[i] = k_lat[i];
    end
`else
    always_comb begin
        rk_src[0]  = key;
        rk_src[1]  = round1_key;
        rk_src[2]  = round2_key;
        rk_src[3]  = round3_key;
        rk_src[4]  = round4_key;
        rk_src[5]  = round5_key;
        rk_src[6]  = round6_key;
        rk_src[7]  = round7_key;
        rk_src[8]  = round8_key;
        rk_src[9]  = round9_key;
        rk_src[10] = round10_key;
    end
`endif

    // cnt doubles as the round-key index; cnt==0 selects the cipher key for the final round.
    always_comb begin
        rk_sel    = rk_src[10];
        if (cnt <= 4'd10) rk_sel = rk_src[cnt];
        sub_out   = inv_sub_bytes(inv_shift_rows(st));
        ark       = sub_out ^ rk_sel;
        round_out = inv_mix_columns(ark);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            st        <= '0;
            plain_out <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        st       <= cipher_in ^ round10_key;
                        cnt      <= 4'd9;
                        state    <= S_ROUND;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_ROUND: begin
                    if (cnt != 4'd0) begin
                        st  <= round_out;
                        cnt <= cnt - 4'd1;
                    end else begin
                        plain_out <= ark;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
